// File: rtl/dmem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_pkg
// Shared definitions for the data-memory arbiter: default bus widths, the
// starvation counter width and the encoding of the registered read-owner tag.
// -----------------------------------------------------------------------------
package dmem_arbiter_pkg;

   localparam int unsigned DEF_ADDR_W = 12;
   localparam int unsigned DEF_DATA_W = 32;
   localparam int unsigned STARVE_W   = 8;

   // Which requester owns the read data returning from RAM next cycle.
   typedef enum logic [1:0] {
      OWN_NONE   = 2'd0,
      OWN_CPU_RD = 2'd1,
      OWN_VGA_RD = 2'd2
   } owner_e;

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Counter that increments up to LIMIT and holds there; clear has priority.
// Ports:
//   clk, rst      clock, async active-high reset
//   inc_i         count up this cycle (ignored once at LIMIT)
//   clr_i         synchronous clear to zero
//   cnt_o         current count
// -----------------------------------------------------------------------------
module sat_counter
   import dmem_arbiter_pkg::*;
#(
   parameter int unsigned WIDTH = STARVE_W,
   parameter int unsigned LIMIT = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [WIDTH-1:0] cnt_o
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   // Next count: clear wins, otherwise step up unless saturated.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != WIDTH'(LIMIT))) begin
         cnt_d = cnt_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares one single-port RAM between a CPU (read/write, stalls when denied)
// and a VGA reader (holds its request until granted). The CPU normally wins;
// after STARVE_LIMIT consecutive denied VGA cycles the VGA port is forced a
// grant for one cycle. Read data returns one cycle after the grant and is
// qualified by a per-requester rvalid decoded from a registered owner tag.
// Ports:
//   clk, rst                         clock, async active-high reset
//   cpu_req/wEn/addr/dataIn          CPU access request
//   cpu_stall                        CPU access not serviced this cycle
//   cpu_rvalid, cpu_dataOut          CPU read return
//   vga_req/addr, vga_gnt            VGA read request and acceptance
//   vga_rvalid, vga_dataOut          VGA read return
//   ram_wEn/addr/dataIn, ram_dataOut RAM port (read data one cycle late)
// -----------------------------------------------------------------------------
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W       = DEF_ADDR_W,
   parameter int unsigned DATA_W       = DEF_DATA_W,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic              clk,
   input  logic              rst,
   // CPU port
   input  logic              cpu_req,
   input  logic              cpu_wEn,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_dataIn,
   output logic              cpu_stall,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_dataOut,
   // VGA port
   input  logic              vga_req,
   input  logic [ADDR_W-1:0] vga_addr,
   output logic              vga_gnt,
   output logic              vga_rvalid,
   output logic [DATA_W-1:0] vga_dataOut,
   // RAM port
   output logic              ram_wEn,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_dataIn,
   input  logic [DATA_W-1:0] ram_dataOut
);

   logic [STARVE_W-1:0] starve_cnt;
   logic                vga_force;
   logic                cpu_gnt;
   logic                starve_inc;
   owner_e              owner_q;
   owner_e              owner_d;

   // Consecutive denied VGA cycles; any grant or idle VGA cycle restarts it.
   assign starve_inc = vga_req && !vga_gnt;

   sat_counter #(
      .WIDTH (STARVE_W),
      .LIMIT (STARVE_LIMIT)
   ) u_starve (
      .clk   (clk),
      .rst   (rst),
      .inc_i (starve_inc),
      .clr_i (!starve_inc),
      .cnt_o (starve_cnt)
   );

   // Grant decision; everything is held off while reset is asserted.
   always_comb begin
      vga_force = !rst && vga_req && (starve_cnt == STARVE_W'(STARVE_LIMIT));
      cpu_gnt   = !rst && cpu_req && !vga_force;
      vga_gnt   = !rst && vga_req && (vga_force || !cpu_req);
      cpu_stall = vga_force && cpu_req;
   end

   // RAM port mux: idle cycles park the address at zero with writes off.
   always_comb begin
      ram_wEn    = 1'b0;
      ram_addr   = '0;
      ram_dataIn = '0;
      if (cpu_gnt) begin
         ram_wEn    = cpu_wEn;
         ram_addr   = cpu_addr;
         ram_dataIn = cpu_dataIn;
      end else if (vga_gnt) begin
         ram_addr   = vga_addr;
      end
   end

   // Owner of the read data arriving next cycle; writes return nothing.
   always_comb begin
      owner_d = OWN_NONE;
      if (cpu_gnt && !cpu_wEn) begin
         owner_d = OWN_CPU_RD;
      end else if (vga_gnt) begin
         owner_d = OWN_VGA_RD;
      end
   end

   // Reset discards any read in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner_q <= OWN_NONE;
      end else begin
         owner_q <= owner_d;
      end
   end

   assign cpu_rvalid  = (owner_q == OWN_CPU_RD);
   assign vga_rvalid  = (owner_q == OWN_VGA_RD);
   assign cpu_dataOut = ram_dataOut;
   assign vga_dataOut = ram_dataOut;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed scenarios plus held-request random traffic against a cycle-level
// reference of the arbitration rules and a shadow copy of memory contents.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

   localparam int unsigned ADDR_W = 12;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned LIMIT  = 8;
   localparam int unsigned DEPTH  = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              cpu_req = 1'b0;
   logic              cpu_wEn = 1'b0;
   logic [ADDR_W-1:0] cpu_addr = '0;
   logic [DATA_W-1:0] cpu_dataIn = '0;
   logic              cpu_stall;
   logic              cpu_rvalid;
   logic [DATA_W-1:0] cpu_dataOut;
   logic              vga_req = 1'b0;
   logic [ADDR_W-1:0] vga_addr = '0;
   logic              vga_gnt;
   logic              vga_rvalid;
   logic [DATA_W-1:0] vga_dataOut;
   logic              ram_wEn;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_dataIn;
   logic [DATA_W-1:0] ram_dataOut;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(
      .ADDR_W       (ADDR_W),
      .DATA_W       (DATA_W),
      .STARVE_LIMIT (LIMIT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cpu_req     (cpu_req),
      .cpu_wEn     (cpu_wEn),
      .cpu_addr    (cpu_addr),
      .cpu_dataIn  (cpu_dataIn),
      .cpu_stall   (cpu_stall),
      .cpu_rvalid  (cpu_rvalid),
      .cpu_dataOut (cpu_dataOut),
      .vga_req     (vga_req),
      .vga_addr    (vga_addr),
      .vga_gnt     (vga_gnt),
      .vga_rvalid  (vga_rvalid),
      .vga_dataOut (vga_dataOut),
      .ram_wEn     (ram_wEn),
      .ram_addr    (ram_addr),
      .ram_dataIn  (ram_dataIn),
      .ram_dataOut (ram_dataOut)
   );

   // Initial memory image; word 0x010 holds 0x1234.
   function automatic logic [DATA_W-1:0] pat(input int unsigned a);
      if (a == 32'h10) return 32'h0000_1234;
      return 32'hA500_0000 ^ 32'(a * 32'h0000_9E37);
   endfunction

   // Synchronous single-port RAM, read data one cycle after the address.
   logic              mem_init = 1'b1;
   logic [DATA_W-1:0] mem [DEPTH];
   always @(posedge clk) begin
      if (mem_init) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= pat(i);
      end else if (ram_wEn) begin
         mem[ram_addr] <= ram_dataIn;
      end
      ram_dataOut <= mem[ram_addr];
   end

   // Reference state
   logic [DATA_W-1:0] shadow [DEPTH];
   int unsigned       m_starve = 0;
   logic              m_cpu_rd = 1'b0;
   logic              m_vga_rd = 1'b0;
   logic [DATA_W-1:0] m_rdata  = '0;

   logic cg, vg, ov;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: drive, check at negedge, advance the reference.
   task automatic step(input logic r, input logic c_req, input logic c_wen,
                       input logic [ADDR_W-1:0] c_addr, input logic [DATA_W-1:0] c_data,
                       input logic v_req, input logic [ADDR_W-1:0] v_addr,
                       output logic e_cg, output logic e_vg, output logic obs_vg);
      logic              force_v, e_stall, e_wen;
      logic [ADDR_W-1:0] e_addr;
      rst        = r;
      cpu_req    = c_req;
      cpu_wEn    = c_wen;
      cpu_addr   = c_addr;
      cpu_dataIn = c_data;
      vga_req    = v_req;
      vga_addr   = v_addr;
      @(negedge clk);
      if (r) begin
         m_starve = 0;
         m_cpu_rd = 1'b0;
         m_vga_rd = 1'b0;
      end
      force_v = !r && v_req && (m_starve == LIMIT);
      e_cg    = !r && c_req && !force_v;
      e_vg    = !r && v_req && (force_v || !c_req);
      e_stall = force_v && c_req;
      e_wen   = e_cg && c_wen;
      e_addr  = e_cg ? c_addr : (e_vg ? v_addr : '0);
      obs_vg  = vga_gnt;
      chk("vga_gnt",    64'(vga_gnt),    64'(e_vg));
      chk("cpu_stall",  64'(cpu_stall),  64'(e_stall));
      chk("ram_wEn",    64'(ram_wEn),    64'(e_wen));
      chk("ram_addr",   64'(ram_addr),   64'(e_addr));
      chk("cpu_rvalid", 64'(cpu_rvalid), 64'(m_cpu_rd));
      chk("vga_rvalid", 64'(vga_rvalid), 64'(m_vga_rd));
      if (m_cpu_rd) chk("cpu_data", 64'(cpu_dataOut), 64'(m_rdata));
      if (m_vga_rd) chk("vga_data", 64'(vga_dataOut), 64'(m_rdata));
      if (e_wen)    chk("ram_dataIn", 64'(ram_dataIn), 64'(c_data));
      m_cpu_rd = e_cg && !c_wen;
      m_vga_rd = e_vg;
      m_rdata  = shadow[e_addr];
      if (e_wen) shadow[c_addr] = c_data;
      if (!r && v_req && !e_vg) begin
         if (m_starve < LIMIT) m_starve++;
      end else begin
         m_starve = 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, cg, vg, ov);
   endtask

   // CPU reads continuously while VGA waits; returns cycle of first observed grant.
   task automatic starve_run(input int max_cyc, output int first);
      first = 0;
      for (int i = 1; i <= max_cyc; i++) begin
         step(1'b0, 1'b1, 1'b0, ADDR_W'(i), '0, 1'b1, 12'h055, cg, vg, ov);
         if (ov && first == 0) first = i;
      end
   endtask

   initial begin
      int          first;
      logic        c_pend, c_wen, v_pend;
      logic [ADDR_W-1:0] c_addr, v_addr;
      logic [DATA_W-1:0] c_data;

      for (int unsigned i = 0; i < DEPTH; i++) shadow[i] = pat(i);

      // Reset state
      step(1'b1, 1'b1, 1'b0, 12'h010, '0, 1'b1, 12'h011, cg, vg, ov);
      mem_init = 1'b0;
      step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, cg, vg, ov);
      idle(1);

      // CPU read of preloaded 0x010
      step(1'b0, 1'b1, 1'b0, 12'h010, '0, 1'b0, '0, cg, vg, ov);
      idle(1);

      // Forced VGA grant on the 9th denied cycle, CPU served on the 10th
      starve_run(10, first);
      chk("starve_first_gnt", 64'(first), 64'(9));
      idle(1);

      // CPU write then VGA read of the same word
      step(1'b0, 1'b1, 1'b1, 12'h020, 32'hDEADBEEF, 1'b0, '0, cg, vg, ov);
      step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 12'h020, cg, vg, ov);
      idle(1);

      // Alternating CPU / VGA reads
      for (int i = 0; i < 8; i++) begin
         if (i % 2 == 0) step(1'b0, 1'b1, 1'b0, ADDR_W'(32 + i), '0, 1'b0, '0, cg, vg, ov);
         else            step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, ADDR_W'(64 + i), cg, vg, ov);
      end
      idle(1);

      // Reset right after a granted VGA read; counter restarts from zero
      step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 12'h020, cg, vg, ov);
      step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, cg, vg, ov);
      step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, cg, vg, ov);
      starve_run(10, first);
      chk("post_reset_gnt", 64'(first), 64'(9));
      idle(1);

      // VGA drops after 5 denied cycles, then needs a full fresh wait
      starve_run(5, first);
      chk("early_no_gnt", 64'(first), 64'(0));
      step(1'b0, 1'b1, 1'b0, 12'h003, '0, 1'b0, '0, cg, vg, ov);
      starve_run(12, first);
      chk("restart_gnt", 64'(first), 64'(9));
      idle(1);

      // Random traffic with held requests and occasional reset
      c_pend = 1'b0; v_pend = 1'b0;
      c_wen = 1'b0; c_addr = '0; c_data = '0; v_addr = '0;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(199) == 0) begin
            step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, cg, vg, ov);
            c_pend = 1'b0;
            v_pend = 1'b0;
         end else begin
            if (!c_pend && ($urandom_range(99) < 70)) begin
               c_pend = 1'b1;
               c_wen  = ($urandom_range(2) == 0);
               c_addr = ADDR_W'($urandom_range(31));
               c_data = DATA_W'($urandom);
            end
            if (!v_pend && ($urandom_range(2) == 0)) begin
               v_pend = 1'b1;
               v_addr = ADDR_W'($urandom_range(31));
            end
            step(1'b0, c_pend, c_wen, c_addr, c_data, v_pend, v_addr, cg, vg, ov);
            if (cg) c_pend = 1'b0;
            if (vg) v_pend = 1'b0;
         end
      end
      idle(2);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
